addr_seq_ctrl: RTL and testbench
================================

Name: addr_seq_ctrl

Overview:
- Sequencer driving the control pins of a 16-bit address counter: two cascaded 8-bit synchronous up/down loadable counters, with low-byte RCO feeding high-byte ENT.
- Loads a start address, then steps the counter up or down once per accepted beat for a programmed length.
- Flags wrap-around and guarantees the counter's async-clear select code is never produced by accident.
- Sits between the microcode/DMA control logic and the address counter chips.

Parameters:
- AW, 16, address/counter width (multiple of 8).
- LW, 16, length counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- clr_req  in  1  request counter clear; sampled only in IDLE; start has priority.
- dir_down  in  1  0 = count up, 1 = count down; captured on start.
- start_addr  in  AW  load value; captured on start.
- length  in  LW  number of beats; captured on start.
- abort  in  1  terminate a running sequence.
- beat_ready  in  1  consumer accepts the current beat.
- cnt_rco_n  in  1  high-byte ripple-carry out, active low.
- cnt_s  out  2  counter select: 00 clear (async), 01 down, 10 load, 11 up/hold.
- cnt_enp_n  out  1  counter count enable P, active low.
- cnt_ent_n  out  1  counter count enable T, active low; low byte only.
- cnt_data  out  AW  counter parallel load data.
- beat_valid  out  1  current address is valid for a beat.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sequence end.
- wrap_err  out  1  sticky; cleared on next accepted start.

Behaviour:
- Reset values: cnt_s=11, cnt_enp_n=1, cnt_ent_n=1, cnt_data=0, beat_valid=0, busy=0, done=0, wrap_err=0, state=IDLE, remaining=0.
- Reset mid-operation returns to these values immediately, without waiting for a clock edge.
- All outputs are registered except cnt_enp_n, which is combinational: cnt_enp_n = ~(state==RUN & beat_ready & ~abort).
- cnt_s changes only on a clock edge and never changes both bits on one edge. A direct 10<->01 transition is forbidden; 11 is always interposed. 00 is driven only in CLEAR.
- States and cnt_s per state:
  - IDLE: S=11, ent_n=1.
    - start -> LOAD: capture dir, addr, length; clear wrap_err.
    - else clr_req -> CLR_PRE.
  - CLR_PRE: S=11, one cycle -> CLEAR.
  - CLEAR: S=01, one cycle -> CLEAR2. This stages 11->01->00 so only one bit changes per edge.
  - CLEAR2: S=00, one cycle -> CLR_POST.
  - CLR_POST: S=01, one cycle -> IDLE_RET.
  - IDLE_RET: S=11 -> IDLE; done pulses here.
  - LOAD: S=10, cnt_data=start_addr, one cycle; counter loads on this edge -> SETTLE.
  - SETTLE: S=11, ent_n=1, one cycle.
    - length==0 -> DONE.
    - else -> RUN with remaining=length-1.
  - RUN: S = dir_down ? 01 : 11 (entered via SETTLE, so 10->11->01 holds), ent_n=0, beat_valid=1.
    - The counter advances on each edge with beat_ready=1.
    - On an accepted beat: if remaining==0 -> EXIT, else remaining--.
    - abort -> EXIT with no advance on that edge; abort has priority over beat_ready.
  - EXIT: S=11, ent_n=1, beat_valid=0, one cycle -> DONE.
  - DONE: S=11, done=1 for one cycle -> IDLE.
- Wrap detection: in RUN, an accepted beat with cnt_rco_n==0 and remaining!=0 sets wrap_err. Examples: terminal count FFFF going up, or 0000 going down, with beats still outstanding. The sequence still continues; the counter wraps modulo 2^AW.
- Latency:
  - start to first beat_valid: 2 cycles.
  - last accepted beat to done: 2 cycles.
  - A full N-beat, no-stall sequence spans N+4 cycles.
- start, clr_req and dir changes while busy are ignored.

Test Plan:
- Up count: start, addr=0x1000, length=4, beat_ready=1 -> S goes 11,10,11,11x4,11. Counter reads 0x1004. done is asserted 8 cycles after start. wrap_err=0.
- Down count: addr=0x0003, length=5, dir_down=1 -> S goes 10->11->01 with no 10->01 edge. Counter wraps to 0xFFFE. wrap_err=1 (rco_n low at 0x0000 with remaining=1).
- Stalls: length=3, beat_ready toggling 1,0,0,1,0,1 -> exactly 3 advances. cnt_enp_n is low only while ready. Final address = start+3.
- Abort: abort asserted after 2 of 10 beats -> address = start+2, EXIT then DONE, done pulses once.
- Length=0 and clear: length=0 -> LOAD only, no beat_valid, done after 3 cycles. clr_req -> S goes 11,01,00,01,11; S=00 appears for exactly one cycle.
- Async reset asserted mid-RUN between clock edges -> all outputs reach reset values immediately. A start in the following cycle works normally.

Source files
------------

// File: rtl/addr_seq_ctrl.sv
// rtl/addr_seq_ctrl.sv - control-pin sequencer for a cascaded 16-bit up/down/load address counter
// Loads a start address, steps it once per accepted beat, and stages select codes so S never flips both bits.
module addr_seq_ctrl #(
   parameter int AW = 16,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          clr_req,
   input  logic          dir_down,
   input  logic [AW-1:0] start_addr,
   input  logic [LW-1:0] length,
   input  logic          abort,
   input  logic          beat_ready,
   input  logic          cnt_rco_n,
   output logic [1:0]    cnt_s,
   output logic          cnt_enp_n,
   output logic          cnt_ent_n,
   output logic [AW-1:0] cnt_data,
   output logic          beat_valid,
   output logic          busy,
   output logic          done,
   output logic          wrap_err
);

   typedef enum logic [3:0] {
      IDLE, CLR_PRE, CLEAR, CLEAR2, CLR_POST, IDLE_RET,
      LOAD, SETTLE, RUN, EXIT, DONE
   } state_t;

   localparam logic [1:0] S_CLR  = 2'b00;
   localparam logic [1:0] S_DOWN = 2'b01;
   localparam logic [1:0] S_LOAD = 2'b10;
   localparam logic [1:0] S_UP   = 2'b11;

   state_t          r_state;
   logic            r_dir;
   logic [LW-1:0]   r_len;
   logic [LW-1:0]   r_rem;
   logic [1:0]      r_s;
   logic            r_ent_n;
   logic [AW-1:0]   r_data;
   logic            r_bv;
   logic            r_busy;
   logic            r_done;
   logic            r_wrap;

   assign cnt_s      = r_s;
   assign cnt_ent_n  = r_ent_n;
   assign cnt_data   = r_data;
   assign beat_valid = r_bv;
   assign busy       = r_busy;
   assign done       = r_done;
   assign wrap_err   = r_wrap;

   // Count enable P is the only unregistered output so a beat advances on the very edge it is accepted.
   assign cnt_enp_n = ~((r_state == RUN) & beat_ready & ~abort);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_dir   <= 1'b0;
         r_len   <= '0;
         r_rem   <= '0;
         r_s     <= S_UP;
         r_ent_n <= 1'b1;
         r_data  <= '0;
         r_bv    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= LOAD;
                  r_dir   <= dir_down;
                  r_len   <= length;
                  r_data  <= start_addr;
                  r_wrap  <= 1'b0;
                  r_s     <= S_LOAD;
                  r_busy  <= 1'b1;
               end else if (clr_req) begin
                  r_state <= CLR_PRE;
                  r_s     <= S_UP;
                  r_busy  <= 1'b1;
               end
            end
            // Clear is reached 11->01->00 and left 00->01->11 so only one select bit moves per edge.
            CLR_PRE: begin
               r_state <= CLEAR;
               r_s     <= S_DOWN;
            end
            CLEAR: begin
               r_state <= CLEAR2;
               r_s     <= S_CLR;
            end
            CLEAR2: begin
               r_state <= CLR_POST;
               r_s     <= S_DOWN;
            end
            CLR_POST: begin
               r_state <= IDLE_RET;
               r_s     <= S_UP;
               r_done  <= 1'b1;
            end
            IDLE_RET: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            LOAD: begin
               r_state <= SETTLE;
               r_s     <= S_UP;
            end
            SETTLE: begin
               if (r_len == '0) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= RUN;
                  r_rem   <= r_len - 1'b1;
                  r_s     <= r_dir ? S_DOWN : S_UP;
                  r_ent_n <= 1'b0;
                  r_bv    <= 1'b1;
               end
            end
            RUN: begin
               if (abort || (beat_ready && r_rem == '0)) begin
                  r_state <= EXIT;
                  r_s     <= S_UP;
                  r_ent_n <= 1'b1;
                  r_bv    <= 1'b0;
               end else if (beat_ready) begin
                  r_rem <= r_rem - 1'b1;
               end
               if (!abort && beat_ready && !cnt_rco_n && r_rem != '0) begin
                  r_wrap <= 1'b1;
               end
            end
            EXIT: begin
               r_state <= DONE;
               r_done  <= 1'b1;
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_s     <= S_UP;
               r_ent_n <= 1'b1;
               r_bv    <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// tb/tb_addr_seq_ctrl.sv - scoreboard bench for addr_seq_ctrl with a behavioural model of the counter chips
// Stimulus pushes expected sequence results; a monitor pops them on every done pulse.
module tb_addr_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        clr_req = 1'b0;
   logic        dir_down = 1'b0;
   logic [15:0] start_addr = '0;
   logic [15:0] length = '0;
   logic        abort = 1'b0;
   logic        beat_ready = 1'b0;
   logic        cnt_rco_n;
   logic [1:0]  cnt_s;
   logic        cnt_enp_n;
   logic        cnt_ent_n;
   logic [15:0] cnt_data;
   logic        beat_valid;
   logic        busy;
   logic        done;
   logic        wrap_err;

   addr_seq_ctrl #(.AW(16), .LW(16)) dut (
      .clk(clk), .rst(rst), .start(start), .clr_req(clr_req), .dir_down(dir_down),
      .start_addr(start_addr), .length(length), .abort(abort), .beat_ready(beat_ready),
      .cnt_rco_n(cnt_rco_n), .cnt_s(cnt_s), .cnt_enp_n(cnt_enp_n), .cnt_ent_n(cnt_ent_n),
      .cnt_data(cnt_data), .beat_valid(beat_valid), .busy(busy), .done(done), .wrap_err(wrap_err)
   );

   always #5 clk = ~clk;

   // Counter chips: S=10 load, 00 clear, 11 up, 01 down; advance needs both enables low.
   logic [15:0] m_cnt = 16'h0000;
   always @(posedge clk) begin
      if (cnt_s == 2'b10) m_cnt <= cnt_data;
      else if (cnt_s == 2'b00) m_cnt <= 16'h0000;
      else if (!cnt_enp_n && !cnt_ent_n) m_cnt <= (cnt_s == 2'b11) ? m_cnt + 16'h1 : m_cnt - 16'h1;
   end
   assign cnt_rco_n = ~(!cnt_ent_n && ((cnt_s == 2'b11 && m_cnt == 16'hFFFF) ||
                                       (cnt_s == 2'b01 && m_cnt == 16'h0000)));

   typedef struct {
      int addr;
      int wrap;
      int cyc;
      int adv;
      int s00;
      int bv;
   } exp_t;

   exp_t q[$];
   int tests = 0;
   int fails = 0;
   int viol  = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   int m_cyc = 0, m_adv = 0, m_s00 = 0, m_bv = 0;
   logic [1:0] m_prev_s = 2'b11;
   logic m_prev_busy = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (busy && !m_prev_busy) begin
         m_cyc = 0; m_adv = 0; m_s00 = 0; m_bv = 0;
      end
      if (busy) m_cyc++;
      if (!cnt_enp_n && !cnt_ent_n) m_adv++;
      if (cnt_s == 2'b00) m_s00++;
      if (beat_valid) m_bv++;
      if (cnt_enp_n !== ~(beat_valid & beat_ready & ~abort)) viol++;
      if ((m_prev_s ^ cnt_s) == 2'b11) viol++;
      if (cnt_s == 2'b00 && !busy) viol++;
      if (done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            chk("final_addr", int'(m_cnt), e.addr);
            chk("wrap_err", int'(wrap_err), e.wrap);
            chk("done_cycle", m_cyc, e.cyc);
            chk("advances", m_adv, e.adv);
            chk("s00_cycles", m_s00, e.s00);
            chk("beat_valid_cycles", m_bv, e.bv);
         end
      end
      m_prev_s = cnt_s;
      m_prev_busy = busy;
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cnt_s"}, int'(cnt_s), 3);
      chk({tag, "_enp_n"}, int'(cnt_enp_n), 1);
      chk({tag, "_ent_n"}, int'(cnt_ent_n), 1);
      chk({tag, "_cnt_data"}, int'(cnt_data), 0);
      chk({tag, "_beat_valid"}, int'(beat_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_wrap_err"}, int'(wrap_err), 0);
   endtask

   task automatic run_seq(input logic [15:0] a, input logic [15:0] len, input logic dn,
                          input logic [15:0] rdy, input logic [15:0] ab, input logic clr,
                          input exp_t e);
      int k;
      logic seen;
      @(negedge clk);
      q.push_back(e);
      if (clr) clr_req = 1'b1;
      else begin
         start = 1'b1; dir_down = dn; start_addr = a; length = len;
      end
      @(negedge clk);
      start = 1'b0; clr_req = 1'b0; dir_down = ~dn;
      k = 0; seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (beat_valid) begin
            beat_ready = (k < 16) ? rdy[k] : 1'b1;
            abort      = (k < 16) ? ab[k] : 1'b0;
            k++;
         end else begin
            beat_ready = 1'b0; abort = 1'b0;
         end
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 0, 1);
      beat_ready = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);
      //                 addr      len    dn    ready     abort    clr    addr     wrap cyc adv s00 bv
      run_seq(16'h1000, 16'd4,  1'b0, 16'hFFFF, 16'h0000, 1'b0, '{32'h1000 + 4, 0,  8, 4, 0, 4});
      run_seq(16'h0003, 16'd5,  1'b1, 16'hFFFF, 16'h0000, 1'b0, '{32'hFFFE,     1,  9, 5, 0, 5});
      run_seq(16'h00F0, 16'd3,  1'b0, 16'hFFE9, 16'h0000, 1'b0, '{32'h00F3,     0, 10, 3, 0, 6});
      run_seq(16'h0100, 16'd10, 1'b0, 16'hFFFF, 16'h0004, 1'b0, '{32'h0102,     0,  7, 2, 0, 3});
      run_seq(16'h4000, 16'd0,  1'b0, 16'hFFFF, 16'h0000, 1'b0, '{32'h4000,     0,  3, 0, 0, 0});
      run_seq(16'h0000, 16'd0,  1'b0, 16'h0000, 16'h0000, 1'b1, '{32'h0000,     0,  5, 0, 1, 0});

      @(negedge clk);
      start = 1'b1; dir_down = 1'b0; start_addr = 16'h2000; length = 16'd10;
      @(negedge clk);
      start = 1'b0; beat_ready = 1'b1;
      for (int i = 0; i < 20 && !beat_valid; i++) @(negedge clk);
      chk("reached_run", int'(beat_valid), 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_reset_vals("async_reset");
      @(negedge clk);
      rst = 1'b0; beat_ready = 1'b0;
      run_seq(16'h0010, 16'd2,  1'b0, 16'hFFFF, 16'h0000, 1'b0, '{32'h0012,     0,  6, 2, 0, 2});

      repeat (2) @(negedge clk);
      chk("select_and_enable_invariants", viol, 0);
      chk("scoreboard_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
